// File: rtl/npu_pkg.sv
// Shared NPU constants, the per-beat requantization config record and an int32 saturator.
package npu_pkg;

  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned OUT_WIDTH = 8;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;
  localparam logic signed [7:0]  INT8_MIN  = 8'sh80;
  localparam logic signed [7:0]  INT8_MAX  = 8'sh7f;

  typedef struct packed {
    logic signed [31:0] mult;
    logic        [4:0]  shift;
    logic signed [7:0]  zp;
    logic signed [7:0]  act_min;
    logic signed [7:0]  act_max;
  } requant_cfg_t;

  localparam requant_cfg_t CFG_RESET = '{
    mult:    '0,
    shift:   '0,
    zp:      '0,
    act_min: INT8_MIN,
    act_max: INT8_MAX
  };

  function automatic logic signed [31:0] sat_int32(input logic signed [64:0] v);
    logic signed [31:0] res;
    if (v > 65'(INT32_MAX)) begin
      res = INT32_MAX;
    end else if (v < 65'(INT32_MIN)) begin
      res = INT32_MIN;
    end else begin
      res = v[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One group lane of the requantizer: bias add, Q31 doubling-high multiply, rounding shift,
// zero-point add and activation clamp, one register per stage.
module requant_lane (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en_s1,
  input  logic                                 en_s2,
  input  logic                                 en_s3,
  input  logic                                 en_s4,
  input  logic signed [npu_pkg::ACC_WIDTH-1:0] acc,
  input  logic signed [31:0]                   bias,
  input  logic signed [31:0]                   mult,
  input  logic        [4:0]                    shift,
  input  logic signed [7:0]                    zp,
  input  logic signed [7:0]                    act_min,
  input  logic signed [7:0]                    act_max,
  output logic        [npu_pkg::OUT_WIDTH-1:0] q
);
  import npu_pkg::*;

  logic signed [31:0]    x_d, x_q;
  logic signed [63:0]    p_d, p_q;
  logic signed [31:0]    r_d, r_q;
  logic [OUT_WIDTH-1:0]  q_d, q_q;

  logic signed [64:0]    rnd;
  logic signed [31:0]    h, h_shr, y, lo, hi;
  logic        [31:0]    mask, rem;
  logic        [32:0]    thr;
  logic                  round_up;

  always_comb begin
    x_d = sat_int32({{33{acc[31]}}, acc} + {{33{bias[31]}}, bias});

    p_d = {{32{x_q[31]}}, x_q} * {{32{mult[31]}}, mult};

    rnd = {p_q[63], p_q} + 65'sd1073741824;
    h   = sat_int32(rnd >>> 31);

    // Negative values get a threshold one higher so ties round away from zero.
    mask     = (32'd1 << shift) - 32'd1;
    rem      = h & mask;
    thr      = {1'b0, mask >> 1} + {32'd0, h[31]};
    round_up = {1'b0, rem} > thr;
    h_shr    = h >>> shift;
    r_d      = h_shr + $signed({31'd0, round_up});

    lo = {{24{act_min[7]}}, act_min};
    hi = {{24{act_max[7]}}, act_max};
    y  = sat_int32({{33{r_q[31]}}, r_q} + {{57{zp[7]}}, zp});
    if (y < lo) y = lo;
    if (y > hi) y = hi;
    q_d = y[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      p_q <= '0;
      r_q <= '0;
      q_q <= '0;
    end else begin
      if (en_s1) x_q <= x_d;
      if (en_s2) p_q <= p_d;
      if (en_s3) r_q <= r_d;
      if (en_s4) q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mac_requant.sv
// Requantizes up to MAX_GROUPS int32 group sums to packed int8 in a 4-stage pipeline.
// Config is snapshotted per beat at stage 1 and carried down alongside the data.
module mac_requant #(
  parameter int unsigned MAX_GROUPS = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_we,
  input  logic [MAX_GROUPS*32-1:0]         cfg_bias,
  input  logic [31:0]                      cfg_mult,
  input  logic [4:0]                       cfg_shift,
  input  logic [7:0]                       cfg_zp,
  input  logic [7:0]                       cfg_act_min,
  input  logic [7:0]                       cfg_act_max,
  input  logic [MAX_GROUPS*ACC_WIDTH-1:0]  acc_in,
  input  logic                             valid_in,
  input  logic [3:0]                       num_groups_i,
  output logic [MAX_GROUPS*OUT_WIDTH-1:0]  q_out,
  output logic                             valid_out,
  output logic [3:0]                       num_groups_o
);
  import npu_pkg::*;

  requant_cfg_t              cfg_q, cfg_s1_q;
  logic [MAX_GROUPS*32-1:0]  bias_q;
  logic        [4:0]         shift_s2_q;
  logic signed [7:0]         zp_s2_q, zp_s3_q;
  logic signed [7:0]         min_s2_q, min_s3_q;
  logic signed [7:0]         max_s2_q, max_s3_q;
  logic [3:0]                valid_q;
  logic [3:0]                ng_q [4];
  logic [OUT_WIDTH-1:0]      lane_q [MAX_GROUPS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_q  <= CFG_RESET;
      bias_q <= '0;
    end else if (cfg_we) begin
      cfg_q  <= '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp,
                  act_min: cfg_act_min, act_max: cfg_act_max};
      bias_q <= cfg_bias;
    end
  end

  // valid_q[k] marks stage k+1; side data only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      cfg_s1_q   <= CFG_RESET;
      shift_s2_q <= '0;
      zp_s2_q    <= '0;
      zp_s3_q    <= '0;
      min_s2_q   <= '0;
      min_s3_q   <= '0;
      max_s2_q   <= '0;
      max_s3_q   <= '0;
      for (int k = 0; k < 4; k++) ng_q[k] <= '0;
    end else begin
      valid_q <= {valid_q[2:0], valid_in};
      if (valid_in) begin
        ng_q[0]  <= num_groups_i;
        cfg_s1_q <= cfg_q;
      end
      if (valid_q[0]) begin
        ng_q[1]    <= ng_q[0];
        shift_s2_q <= cfg_s1_q.shift;
        zp_s2_q    <= cfg_s1_q.zp;
        min_s2_q   <= cfg_s1_q.act_min;
        max_s2_q   <= cfg_s1_q.act_max;
      end
      if (valid_q[1]) begin
        ng_q[2]  <= ng_q[1];
        zp_s3_q  <= zp_s2_q;
        min_s3_q <= min_s2_q;
        max_s3_q <= max_s2_q;
      end
      if (valid_q[2]) ng_q[3] <= ng_q[2];
    end
  end

  for (genvar g = 0; g < MAX_GROUPS; g++) begin : g_lane
    requant_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_s1   (valid_in),
      .en_s2   (valid_q[0]),
      .en_s3   (valid_q[1]),
      .en_s4   (valid_q[2]),
      .acc     (acc_in[g*ACC_WIDTH +: ACC_WIDTH]),
      .bias    (bias_q[g*32 +: 32]),
      .mult    (cfg_s1_q.mult),
      .shift   (shift_s2_q),
      .zp      (zp_s3_q),
      .act_min (min_s3_q),
      .act_max (max_s3_q),
      .q       (lane_q[g])
    );

    assign q_out[g*OUT_WIDTH +: OUT_WIDTH] = (32'(num_groups_o) > g) ? lane_q[g] : '0;
  end

  assign valid_out    = valid_q[3];
  assign num_groups_o = ng_q[3];

endmodule

// File: tb/tb_mac_requant.sv
// Randomized self-checking bench for mac_requant; expected beats come from a plain
// integer requantization model and are matched in order by a scoreboard.
module tb_mac_requant;
  localparam int G = 8;
  localparam longint I32_MAX = 64'sd2147483647;
  localparam longint I32_MIN = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [G*32-1:0] cfg_bias;
  logic [31:0]     cfg_mult;
  logic [4:0]      cfg_shift;
  logic [7:0]      cfg_zp, cfg_act_min, cfg_act_max;
  logic [G*32-1:0] acc_in;
  logic            valid_in;
  logic [3:0]      num_groups_i;
  logic [G*8-1:0]  q_out;
  logic            valid_out;
  logic [3:0]      num_groups_o;

  mac_requant #(
    .MAX_GROUPS (G),
    .ACC_WIDTH  (32),
    .OUT_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_bias     (cfg_bias),
    .cfg_mult     (cfg_mult),
    .cfg_shift    (cfg_shift),
    .cfg_zp       (cfg_zp),
    .cfg_act_min  (cfg_act_min),
    .cfg_act_max  (cfg_act_max),
    .acc_in       (acc_in),
    .valid_in     (valid_in),
    .num_groups_i (num_groups_i),
    .q_out        (q_out),
    .valid_out    (valid_out),
    .num_groups_o (num_groups_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // m_* is the config the DUT currently holds; n_* is the next value to write.
  longint m_mult, m_shift, m_zp, m_min, m_max;
  longint n_mult, n_shift, n_zp, n_min, n_max;
  longint m_bias[G];
  longint n_bias[G];
  longint acc_v[G];

  typedef struct {
    logic [63:0] q;
    logic [3:0]  ng;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > I32_MAX) return I32_MAX;
    if (v < I32_MIN) return I32_MIN;
    return v;
  endfunction

  function automatic logic [7:0] ref_lane(input longint acc, input longint bias);
    longint x, h, r, a, y;
    x = sat32(acc + bias);
    // x*mult/2^31 rounded to nearest, halves upward
    h = sat32((x * m_mult + (64'sd1 <<< 30)) >>> 31);
    if (m_shift == 0) begin
      r = h;
    end else begin
      a = (h < 0) ? -h : h;
      a = (a + (64'sd1 <<< (m_shift - 1))) >>> m_shift;
      r = (h < 0) ? -a : a;
    end
    y = sat32(r + m_zp);
    if (y < m_min) y = m_min;
    if (y > m_max) y = m_max;
    return y[7:0];
  endfunction

  function automatic logic [63:0] ref_beat(input logic [3:0] ng);
    logic [63:0] w;
    w = '0;
    for (int g = 0; g < G; g++)
      if (g < int'(ng)) w[g*8 +: 8] = ref_lane(acc_v[g], m_bias[g]);
    return w;
  endfunction

  task automatic reset_model();
    m_mult = 0; m_shift = 0; m_zp = 0; m_min = -128; m_max = 127;
    for (int g = 0; g < G; g++) m_bias[g] = 0;
  endtask

  task automatic set_next(input longint mult, input longint shift, input longint zp,
                          input longint mn, input longint mx, input longint bias);
    n_mult = mult; n_shift = shift; n_zp = zp; n_min = mn; n_max = mx;
    for (int g = 0; g < G; g++) n_bias[g] = bias;
  endtask

  task automatic set_acc(input longint v);
    for (int g = 0; g < G; g++) acc_v[g] = v;
  endtask

  task automatic drive(input bit v, input logic [3:0] ng, input bit we);
    exp_t e;
    @(posedge clk);
    #1;
    valid_in     = v;
    num_groups_i = ng;
    cfg_we       = we;
    for (int g = 0; g < G; g++) acc_in[g*32 +: 32] = acc_v[g][31:0];
    if (v) begin
      e.q   = ref_beat(ng);
      e.ng  = ng;
      e.due = cyc + 4;
      exp_q.push_back(e);
    end
    if (we) begin
      cfg_mult    = n_mult[31:0];
      cfg_shift   = n_shift[4:0];
      cfg_zp      = n_zp[7:0];
      cfg_act_min = n_min[7:0];
      cfg_act_max = n_max[7:0];
      for (int g = 0; g < G; g++) cfg_bias[g*32 +: 32] = n_bias[g][31:0];
      m_mult = n_mult; m_shift = n_shift; m_zp = n_zp; m_min = n_min; m_max = n_max;
      for (int g = 0; g < G; g++) m_bias[g] = n_bias[g];
    end
  endtask

  task automatic drain();
    repeat (6) drive(1'b0, 4'd0, 1'b0);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic longint rand_s8();
    return longint'($signed(8'($urandom)));
  endfunction

  task automatic rand_next();
    longint a, b, t;
    case ($urandom_range(0, 2))
      0:       n_mult = 64'sd1 <<< 30;
      1:       n_mult = longint'($urandom_range(0, 32'h7fff_ffff));
      default: n_mult = longint'($urandom_range(32'h4000_0000, 32'h7fff_ffff));
    endcase
    n_shift = ($urandom_range(0, 4) == 0) ? longint'($urandom_range(0, 31))
                                          : longint'($urandom_range(0, 8));
    n_zp = rand_s8();
    a = rand_s8();
    b = rand_s8();
    if ($urandom_range(0, 9) != 0 && a > b) begin
      t = a; a = b; b = t;
    end
    n_min = a;
    n_max = b;
    for (int g = 0; g < G; g++)
      n_bias[g] = ($urandom_range(0, 1) == 1) ? longint'($signed($urandom))
                                              : longint'($urandom_range(0, 4000)) - 2000;
  endtask

  task automatic rand_acc();
    for (int g = 0; g < G; g++)
      case ($urandom_range(0, 3))
        0, 1: acc_v[g] = longint'($urandom_range(0, 10000)) - 5000;
        2:    acc_v[g] = longint'($signed($urandom));
        default: acc_v[g] = ($urandom_range(0, 1) == 1)
                            ? I32_MAX - longint'($urandom_range(0, 100))
                            : I32_MIN + longint'($urandom_range(0, 100));
      endcase
  endtask

  // In-order scoreboard on the output side.
  always @(posedge clk) begin
    #2;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {63'd0, valid_out}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("q_out", q_out, mon_e.q);
        check_eq("num_groups_o", {60'd0, num_groups_o}, {60'd0, mon_e.ng});
        check_eq("latency", 64'(cyc), 64'(mon_e.due));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      check_eq("valid_out", {63'd0, valid_out}, 64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
    cfg_zp = '0; cfg_act_min = '0; cfg_act_max = '0; acc_in = '0; valid_in = 1'b0;
    num_groups_i = '0;
    reset_model();
    set_acc(0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid_out", {63'd0, valid_out}, 64'd0);
    check_eq("rst_q_out", q_out, 64'd0);
    check_eq("rst_num_groups", {60'd0, num_groups_o}, 64'd0);
    rst = 1'b1;

    // Basic: 1024 * 0.5 = 512, >>2 = 128, -128 -> 0
    set_next(64'sd1 <<< 30, 2, -128, -128, 127, 24);
    drive(1'b0, 4'd0, 1'b1);
    set_acc(1000);
    drive(1'b1, 4'd8, 1'b0);
    drain();

    // Saturation at both clamp ends
    set_next(64'sd1 <<< 30, 0, 0, -128, 127, 0);
    drive(1'b0, 4'd0, 1'b1);
    set_acc(100000);
    drive(1'b1, 4'd8, 1'b0);
    set_acc(-100000);
    drive(1'b1, 4'd8, 1'b0);
    drain();

    // Rounding ties away from zero
    set_next(64'sd2147483647, 2, 0, -128, 127, 0);
    drive(1'b0, 4'd0, 1'b1);
    set_acc(-6);
    drive(1'b1, 4'd8, 1'b0);
    set_acc(6);
    drive(1'b1, 4'd8, 1'b0);
    set_next(64'sd2147483647, 1, 0, -128, 127, 0);
    drive(1'b0, 4'd0, 1'b1);
    set_acc(3);
    drive(1'b1, 4'd8, 1'b0);
    drain();

    // Streaming, 16 back-to-back beats on 5 groups
    set_next(64'sd1 <<< 30, 1, 3, -128, 127, 0);
    for (int g = 0; g < G; g++) n_bias[g] = g * 10;
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < G; g++) acc_v[g] = i * 37 - 300 + g * 23;
      drive(1'b1, 4'd5, 1'b0);
    end
    drain();

    // Zero point change alongside beat 3: beats 0-3 old zp, 4+ new zp
    set_next(64'sd1 <<< 30, 0, 0, -128, 127, 0);
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < G; g++) acc_v[g] = 20 * (i + 1) + 2 * g;
      if (i == 3) begin
        set_next(64'sd1 <<< 30, 0, 10, -128, 127, 0);
        drive(1'b1, 4'd8, 1'b1);
      end else begin
        drive(1'b1, 4'd8, 1'b0);
      end
    end
    drain();

    // Random traffic with gaps and occasional config writes
    for (int it = 0; it < 300; it++) begin
      bit we;
      bit v;
      we = ($urandom_range(0, 9) == 0);
      if (we) rand_next();
      v = ($urandom_range(0, 3) != 0);
      rand_acc();
      drive(v, 4'($urandom_range(0, 15)), we);
    end
    drain();

    // Reset with three beats in flight
    rand_next();
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_acc();
      drive(1'b1, 4'd8, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_in = 1'b0;
    cfg_we = 1'b0;
    exp_q.delete();
    reset_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("midrst_q_out", q_out, 64'd0);
    check_eq("midrst_num_groups", {60'd0, num_groups_o}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      check_eq("midrst_valid_out", {63'd0, valid_out}, 64'd0);
      @(posedge clk);
      #1;
    end
    // Post-reset config is the reset default
    rand_acc();
    drive(1'b1, 4'd8, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_requant.md
Name: mac_requant

Overview:
- Sits directly downstream of the grouped MAC reduction stage.
- Takes up to MAX_GROUPS signed 32-bit per-group accumulator sums and requantizes each one to int8, TFLite-style: bias add, fixed-point multiply, rounding shift, zero-point add, activation clamp.
- Fully pipelined, one input beat accepted per cycle.
- Packed int8 results plus group count are handed to the output writeback / activation buffer.

Parameters:
- MAX_GROUPS, 8, number of parallel group lanes.
- ACC_WIDTH, 32, width of each input accumulator lane.
- OUT_WIDTH, 8, width of each requantized output lane.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- cfg_we  input  1  load the configuration registers this cycle.
- cfg_bias  input  MAX_GROUPS*32  per-group signed bias.
- cfg_mult  input  32  signed Q31 output multiplier, must be >= 0.
- cfg_shift  input  5  right shift, 0..31.
- cfg_zp  input  8  signed output zero point.
- cfg_act_min  input  8  signed clamp low bound.
- cfg_act_max  input  8  signed clamp high bound.
- acc_in  input  MAX_GROUPS*ACC_WIDTH  signed per-group sums; lane g at [g*32 +: 32].
- valid_in  input  1  acc_in is valid.
- num_groups_i  input  4  active groups in the beat.
- q_out  output  MAX_GROUPS*OUT_WIDTH  packed int8 results; lane g at [g*8 +: 8].
- valid_out  output  1  q_out is valid.
- num_groups_o  output  4  num_groups_i delayed to align with q_out.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Config registers cleared; act_min=-128 and act_max=127 after reset.
  - All pipeline valids, q_out and num_groups_o cleared to 0.
  - Reset mid-operation drops every in-flight beat; no valid_out appears for them.
- Config:
  - Registered on cfg_we.
  - The new value applies to beats entering stage 1 on the cycle after the write.
  - cfg_we during traffic is legal; in-flight beats keep the config sampled at stage 1, which is carried down the pipe.
- No backpressure: downstream always accepts. Latency is exactly 4 cycles; valid_in at edge N gives valid_out high after edge N+4.
- S1: x = acc + bias[g], 33-bit signed, saturated to int32.
- S2: p = x * mult, full 64-bit signed product.
- S3: h = (p + 2^30) >>> 31, saturated to int32. This is the saturating rounding doubling high multiply.
  - Then rounding right shift by s:
    - mask = 2^s - 1; rem = h & mask; thr = (mask >> 1) + (h < 0).
    - r = (h >>> s) + (rem > thr).
    - Ties round away from zero; s=0 passes h through.
- S4: y = r + sign_extend(zp), saturated to int32, then clamped to [act_min, act_max] and truncated to 8 bits.
- Lanes g >= num_groups_o output 0x00.
- num_groups_i = 0 gives valid_out with all lanes 0.
- valid_out and num_groups_o are registered and stage-aligned with q_out.
- Data registers in a stage update only when that stage's valid is 1, which saves toggling; valid bits update every cycle.
- act_min > act_max is illegal config; output is then act_max (clamp-high wins).
- Back-to-back beats every cycle are supported with no bubbles.

Decomposition:
- Shared package (npu_pkg): ACC_WIDTH, OUT_WIDTH, INT32_MIN/MAX, INT8_MIN/MAX, and a saturate-to-int32 function.
- One sub-module, requant_lane: the per-group S1..S4 datapath, instantiated MAX_GROUPS times.
- The top level holds config registers, the valid/num_groups delay line, output zeroing and packing.

Test Plan:
- Basic: bias=24, mult=2^30, shift=2, zp=-128, acc=1000 on all lanes -> 4 cycles later every lane = 0x00.
- Saturation: acc=100000, bias=0, mult=2^30, shift=0, zp=0 -> 127 (0x7F); acc=-100000 -> -128 (0x80).
- Rounding ties: mult=2^31-1, shift=2, zp=0, acc=-6 -> -2 (0xFE); acc=6 -> 2; acc=3 with shift=1 -> 2.
- Streaming: 16 back-to-back beats with a different acc per beat and num_groups_i=5 -> 16 consecutive valid_out; lanes 5..7 are 0; order is preserved; num_groups_o=5.
- Config update mid-stream: change zp from 0 to 10 between beat 3 and beat 4 -> beats 0-3 use zp 0 and beats 4+ are offset by +10 (within the clamp).
- Reset: pulse rst low for 1 cycle with 3 beats in flight -> no valid_out afterwards; q_out=0 and num_groups_o=0; act bounds back to -128/127.
